ahb_sram_slave: RTL and testbench

- AHB-Lite-style responder to the bus masters: word-organised SRAM model answering transfers routed by the address decoder (HSEL).
- Programmable wait states and a two-cycle ERROR response for illegal accesses.
- Sits on the slave side of the interconnect; its HREADYOUT feeds the HREADY mux that returns HREADY to masters and the arbiter.

---
 rtl/ahb_sram_slave.sv | 161 ++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM responder with programmable wait states and a two-cycle ERROR response.
// Optional build macro AHB_SLV_WRITE_PROTECT_EN turns the low RO_BYTES of the array into a write-protected region.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1,
    parameter int RO_BYTES    = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int         DEPTH      = 1 << (ADDR_WIDTH - 2);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [3:0] WAIT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef AHB_SLV_WRITE_PROTECT_EN
    localparam logic [31:0] RO_LIMIT  = 32'(RO_BYTES);
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    state_t                  accept_state_s;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [2:0]              size_q, size_d;
    logic                    hreadyout_q;
    logic [1:0]              hresp_q;
    logic [31:0]             mem_q [DEPTH];
    logic                    accept_s;
    logic                    illegal_s;
    logic [3:0]              lane_en_s;
    logic [ADDR_WIDTH-3:0]   widx_s;
    logic                    unused_s;

    // Byte lanes touched by a transfer of the given size at the given word offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            3'b000:  lane_mask = 4'b0001 << lane;
            3'b001:  lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            3'b010:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Size legality and natural alignment of an address-phase request.
    function automatic logic size_align_bad(input logic [31:0] addr, input logic [2:0] size);
        case (size)
            3'b000:  size_align_bad = 1'b0;
            3'b001:  size_align_bad = addr[0];
            3'b010:  size_align_bad = (addr[1:0] != 2'b00);
            default: size_align_bad = 1'b1;
        endcase
    endfunction

`ifdef AHB_SLV_WRITE_PROTECT_EN
    assign unused_s = ^{HBURST, HTRANS[0]};
`else
    assign unused_s = ^{HBURST, HTRANS[0], RO_BYTES[0]};
`endif

    assign widx_s    = addr_q[ADDR_WIDTH-1:2];
    assign lane_en_s = lane_mask(size_q, addr_q[1:0]);

    // Address-phase acceptance and legality decode.
    always_comb begin
        accept_s  = ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2))
                    && HSEL && HREADY && HTRANS[1];
        illegal_s = size_align_bad(HADDR, HSIZE) || ((HADDR >> ADDR_WIDTH) != 32'd0);
`ifdef AHB_SLV_WRITE_PROTECT_EN
        illegal_s = illegal_s || (HWRITE && (HADDR < RO_LIMIT));
`endif
        accept_state_s = illegal_s ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);
    end

    // Next-state logic; ST_DATA and ST_ERR2 accept pipelined transfers like ST_IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    state_d = accept_state_s;
                    cnt_d   = WAIT_INIT;
                    addr_d  = HADDR[ADDR_WIDTH-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, latched control and registered handshake outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'b000;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
            hresp_q     <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
        end
    end

    // Write commits on the closing edge of the data phase; reset forces ST_IDLE so an aborted write never lands.
    always_ff @(posedge HCLK) begin
        if ((state_q == ST_DATA) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en_s[i]) begin
                    mem_q[widx_s][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem_q[widx_s] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: a byte-array reference model predicts each accepted transfer,
// and an independent monitor checks every data phase as the slave completes it.
`timescale 1ns/1ps
module tb_ahb_sram_slave;

    localparam int AW = 12;
    localparam int WS = 1;
    localparam int RO = 256;
`ifdef AHB_SLV_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL    = 1'b0;
    logic        HWRITE  = 1'b0;
    logic [31:0] HADDR   = 32'd0;
    logic [31:0] HWDATA  = 32'd0;
    logic [1:0]  HTRANS  = 2'b00;
    logic [2:0]  HSIZE   = 3'b000;
    logic [2:0]  HBURST  = 3'b000;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .RO_BYTES(RO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    typedef struct packed {
        bit          sel;
        logic [1:0]  trans;
        bit          write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct packed {
        bit          err;
        bit          rd;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    exp_t       exp_q[$];
    xfer_t      seq_q[$];
    logic [7:0] mem_m [4096];
    bit         kn    [4096];
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void add(input bit sel, input logic [1:0] trans, input bit write,
                                input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.write = write; x.size = size; x.addr = addr; x.wdata = wdata;
        seq_q.push_back(x);
    endfunction

    // Reference model: little-endian byte memory, each transfer touches 2^size consecutive bytes.
    function automatic exp_t predict(input xfer_t x);
        exp_t        e;
        int          nb;
        int          a;
        logic [31:0] base;
        nb = 1 << x.size;
        e.err = (x.size > 3'd2) || ((x.addr % nb) != 0) || ((x.addr >> AW) != 32'd0)
                || (WP && x.write && (x.addr < RO));
        e.rd   = !x.write;
        e.data = 32'd0;
        e.mask = 32'd0;
        if (!e.err) begin
            if (x.write) begin
                for (int k = 0; k < nb; k++) begin
                    a = int'(x.addr) + k;
                    mem_m[a] = x.wdata[8*(a%4) +: 8];
                    kn[a]    = 1'b1;
                end
            end else begin
                base = x.addr & ~32'h3;
                for (int j = 0; j < 4; j++) begin
                    e.data[8*j +: 8] = mem_m[int'(base) + j];
                    e.mask[8*j +: 8] = kn[int'(base) + j] ? 8'hFF : 8'h00;
                end
            end
        end
        return e;
    endfunction

    // Pipelined master: address phase of the next transfer overlaps the data phase of the current one.
    task automatic run();
        bit          have_dp = 1'b0;
        logic [31:0] dp_data = 32'd0;
        bit          rdy;
        int          i = 0;
        int          guard = 0;
        xfer_t       x;
        while (((i < seq_q.size()) || have_dp) && (guard < 5000)) begin
            if (i < seq_q.size()) begin
                x = seq_q[i];
                HSEL = x.sel; HTRANS = x.trans; HWRITE = x.write; HSIZE = x.size; HADDR = x.addr;
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b000; HADDR = 32'd0;
            end
            HWDATA = have_dp ? dp_data : 32'd0;
            @(negedge HCLK);
            rdy = HREADYOUT;
            @(posedge HCLK);
            #1;
            if (rdy) begin
                have_dp = 1'b0;
                if (i < seq_q.size()) begin
                    if (x.sel && x.trans[1]) begin
                        exp_q.push_back(predict(x));
                        have_dp = 1'b1;
                        dp_data = x.wdata;
                    end
                    i++;
                end
            end
            guard++;
        end
        if (guard >= 5000) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_timeout: issued %0d of %0d transfers", i, seq_q.size());
        end
        HSEL = 1'b0; HTRANS = 2'b00;
        seq_q.delete();
    endtask

    // Monitor: tracks data phases from bus signals and checks each completion against the scoreboard.
    initial begin : monitor
        bit   dp = 1'b0;
        bit   prev_idle = 1'b0;
        int   waits = 0;
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dp = 1'b0; prev_idle = 1'b0; waits = 0;
            end else begin
                if (prev_idle) begin
                    check("idle_ready", 32'(HREADYOUT), 32'd1);
                    check("idle_resp", 32'(HRESP), 32'd0);
                end
                if (dp) begin
                    if (!HREADYOUT) begin
                        waits++;
                        check("wait_rdata_zero", HRDATA, 32'd0);
                        if (exp_q.size() > 0) check("wait_resp", 32'(HRESP), exp_q[0].err ? 32'd1 : 32'd0);
                    end else begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_completion: resp %0d rdata 0x%08h with empty scoreboard", HRESP, HRDATA);
                        end else begin
                            e = exp_q.pop_front();
                            check("resp", 32'(HRESP), e.err ? 32'd1 : 32'd0);
                            check("wait_cycles", 32'(waits), e.err ? 32'd1 : 32'(WS));
                            if (e.rd && !e.err) check("rdata", HRDATA & e.mask, e.data & e.mask);
                            else check("rdata_zero", HRDATA, 32'd0);
                        end
                        waits = 0;
                    end
                end
                prev_idle = HSEL && HREADYOUT && !HTRANS[1];
                if (HSEL && HREADYOUT && HTRANS[1]) dp = 1'b1;
                else if (dp && HREADYOUT) dp = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        int          r;

        repeat (2) @(posedge HCLK);
        #1;
        check("reset_ready", 32'(HREADYOUT), 32'd1);
        check("reset_resp", 32'(HRESP), 32'd0);
        check("reset_rdata", HRDATA, 32'd0);
        @(negedge HCLK);
        #2 HRESETn = 1'b1;

        for (int w = 0; w < 128; w++) add(1'b1, 2'b10, 1'b1, 3'b010, 32'(w * 4), $urandom);
        run();

        add(1'b1, 2'b10, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0);
        add(1'b1, 2'b10, 1'b1, 3'b010, 32'h10, 32'h11223344);
        add(1'b1, 2'b10, 1'b1, 3'b000, 32'h13, 32'hAA000000);
        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0);
        add(1'b1, 2'b10, 1'b1, 3'b001, 32'h10, 32'h00005566);
        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0);
        run();

        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h02, 32'h0);
        add(1'b1, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0);
        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h00010000, 32'h0);
        add(1'b1, 2'b10, 1'b1, 3'b001, 32'h11, 32'h0);
        add(1'b1, 2'b10, 1'b0, 3'b011, 32'h18, 32'h0);
        add(1'b1, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0);
        run();

        HBURST = 3'b011;
        for (int b = 0; b < 4; b++) add(1'b1, (b == 0) ? 2'b10 : 2'b11, 1'b1, 3'b010, 32'(32'h20 + b * 4), 32'(b + 1));
        for (int b = 0; b < 4; b++) add(1'b1, (b == 0) ? 2'b10 : 2'b11, 1'b0, 3'b010, 32'(32'h20 + b * 4), 32'h0);
        run();
        HBURST = 3'b000;

        add(1'b1, 2'b00, 1'b1, 3'b010, 32'h20, 32'hFFFFFFFF);
        add(1'b1, 2'b01, 1'b1, 3'b010, 32'h24, 32'hFFFFFFFF);
        add(1'b1, 2'b00, 1'b0, 3'b010, 32'h20, 32'h0);
        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h20, 32'h0);
        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h24, 32'h0);
        run();

        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010; HADDR = 32'h40;
        @(negedge HCLK);
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hBAD0BAD0;
        @(negedge HCLK);
        check("abort_wait_ready", 32'(HREADYOUT), 32'd0);
        #2 HRESETn = 1'b0;
        #1;
        check("abort_ready", 32'(HREADYOUT), 32'd1);
        check("abort_resp", 32'(HRESP), 32'd0);
        check("abort_rdata", HRDATA, 32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        HWDATA = 32'd0;
        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h40, 32'h0);
        run();

        add(1'b1, 2'b10, 1'b1, 3'b000, 32'h80, 32'h00000055);
        add(1'b1, 2'b10, 1'b1, 3'b010, 32'h100, 32'h12345678);
        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h80, 32'h0);
        add(1'b1, 2'b10, 1'b0, 3'b010, 32'h100, 32'h0);
        run();

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            tr = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
            sz = ($urandom_range(0, 9) == 0) ? 3'b011 : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 19) == 0) a = a | 32'h00010000;
            add($urandom_range(0, 9) != 0, tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
        end
        run();

        repeat (3) @(posedge HCLK);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
